cgra_mul_tile: RTL and testbench

CGRA_MUL_TILE -- requirements
Module: cgra_mul_tile

---
 rtl/cgra_mul_tile.sv | 136 +++++++++++++
 tb/tb_cgra_mul_tile.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_mul_tile.sv
// CGRA multiplier tile: four routed inputs feed an N x N multiplier with registered
// operands and product, and eight configurable output muxes drive the neighbour ports.
module cgra_mul_tile #(
  parameter int FW = 32,
  parameter int FH = 2,
  parameter int N  = 12
) (
  input  logic               gclocki,
  input  logic               CLREND,
  output logic               CLRBEG,
  output logic               clk,
  output logic               rst,
  input  logic [FH-1:0]      cfg_strbi,
  output logic [FH-1:0]      cfg_strbo,
  input  logic [FW-1:0]      cfg_datai,
  output logic [FW-1:0]      cfg_datao,
  input  logic [2*(N+1)-1:0] N1END,
  input  logic [2*(N+1)-1:0] S1END,
  input  logic [2*(N+1)-1:0] E1END,
  input  logic [2*(N+1)-1:0] W1END,
  output logic [2*(N+1)-1:0] N1BEG,
  output logic [2*(N+1)-1:0] S1BEG,
  output logic [2*(N+1)-1:0] E1BEG,
  output logic [2*(N+1)-1:0] W1BEG
);

  localparam int WW = N + 1;

  assign CLRBEG    = CLREND;
  assign clk       = gclocki;
  assign rst       = CLREND;
  assign cfg_strbo = cfg_strbi;
  assign cfg_datao = cfg_datai;

  // Config frames are level-sensitive latches; reset intentionally leaves them alone.
  genvar gi;
  generate
    for (gi = 0; gi < FH; gi++) begin : gen_frame
      logic [FW-1:0] frame_reg;
      logic          frame_unused;

      always_latch begin
        if (cfg_strbi[gi]) frame_reg <= cfg_datai;
      end

      // reserved and spare frame bits are sunk here; they drive no logic
      assign frame_unused = ^frame_reg;
    end
  endgenerate

  logic [FW-1:0] route_cfg;
  logic [FW-1:0] mul_cfg;
  assign route_cfg = gen_frame[0].frame_reg;
  assign mul_cfg   = gen_frame[1].frame_reg;

  logic [2:0] a_sel;
  logic [2:0] b_sel;
  logic       half_sel;
  logic       bypass;
  logic       signed_mode;
  assign a_sel       = mul_cfg[2:0];
  assign b_sel       = mul_cfg[5:3];
  assign half_sel    = mul_cfg[6];
  assign bypass      = mul_cfg[7];
  assign signed_mode = mul_cfg[8];

  logic [WW-1:0] in_word [8];
  assign in_word[0] = N1END[WW-1:0];
  assign in_word[1] = N1END[2*WW-1:WW];
  assign in_word[2] = S1END[WW-1:0];
  assign in_word[3] = S1END[2*WW-1:WW];
  assign in_word[4] = E1END[WW-1:0];
  assign in_word[5] = E1END[2*WW-1:WW];
  assign in_word[6] = W1END[WW-1:0];
  assign in_word[7] = W1END[2*WW-1:WW];

  logic [WW-1:0] a_word;
  logic [WW-1:0] b_word;
  assign a_word = in_word[a_sel];
  assign b_word = in_word[b_sel];

  // Extending both operands to 2N bits makes the truncated product exact in either mode.
  logic [2*N-1:0] a_ext;
  logic [2*N-1:0] b_ext;
  logic [2*N-1:0] product;
  assign a_ext   = {{N{signed_mode & a_word[N-1]}}, a_word[N-1:0]};
  assign b_ext   = {{N{signed_mode & b_word[N-1]}}, b_word[N-1:0]};
  assign product = a_ext * b_ext;

  logic [WW-1:0] q_next;
  logic [WW-1:0] q_reg;
  logic [WW-1:0] ar_reg;
  logic [WW-1:0] br_reg;
  logic [WW-1:0] q_word;

  assign q_next = {a_word[N] & b_word[N], half_sel ? product[2*N-1:N] : product[N-1:0]};
  assign q_word = bypass ? q_next : q_reg;

  always_ff @(posedge gclocki or posedge CLREND) begin
    if (CLREND) begin
      q_reg  <= '0;
      ar_reg <= '0;
      br_reg <= '0;
    end else begin
      q_reg  <= q_next;
      ar_reg <= a_word;
      br_reg <= b_word;
    end
  end

  logic [WW-1:0] out_word [8];
  generate
    for (gi = 0; gi < 8; gi++) begin : gen_out
      logic [3:0] src_sel;
      assign src_sel = route_cfg[4*gi +: 4];

      always_comb begin
        out_word[gi] = '0;
        case (src_sel)
          4'd0, 4'd1, 4'd2, 4'd3,
          4'd4, 4'd5, 4'd6, 4'd7: out_word[gi] = in_word[src_sel[2:0]];
          4'd8:                   out_word[gi] = q_word;
          4'd9:                   out_word[gi] = ar_reg;
          4'd10:                  out_word[gi] = br_reg;
          default:                out_word[gi] = '0;
        endcase
      end
    end
  endgenerate

  assign N1BEG = {out_word[1], out_word[0]};
  assign S1BEG = {out_word[3], out_word[2]};
  assign E1BEG = {out_word[5], out_word[4]};
  assign W1BEG = {out_word[7], out_word[6]};

endmodule

// File: tb/tb_cgra_mul_tile.sv
// Directed bench for cgra_mul_tile: stimulus queues expected output values and
// a monitor process pops and compares them at each check point.
module tb_cgra_mul_tile;

  localparam int FW = 32;
  localparam int FH = 2;
  localparam int N  = 12;
  localparam int W  = N + 1;

  logic           gclocki;
  logic           CLREND;
  logic           CLRBEG;
  logic           clk;
  logic           rst;
  logic [FH-1:0]  cfg_strbi;
  logic [FH-1:0]  cfg_strbo;
  logic [FW-1:0]  cfg_datai;
  logic [FW-1:0]  cfg_datao;
  logic [2*W-1:0] N1END, S1END, E1END, W1END;
  logic [2*W-1:0] N1BEG, S1BEG, E1BEG, W1BEG;

  cgra_mul_tile #(.FW(FW), .FH(FH), .N(N)) dut (
    .gclocki  (gclocki),
    .CLREND   (CLREND),
    .CLRBEG   (CLRBEG),
    .clk      (clk),
    .rst      (rst),
    .cfg_strbi(cfg_strbi),
    .cfg_strbo(cfg_strbo),
    .cfg_datai(cfg_datai),
    .cfg_datao(cfg_datao),
    .N1END    (N1END),
    .S1END    (S1END),
    .E1END    (E1END),
    .W1END    (W1END),
    .N1BEG    (N1BEG),
    .S1BEG    (S1BEG),
    .E1BEG    (E1BEG),
    .W1BEG    (W1BEG)
  );

  initial gclocki = 1'b0;
  always #5 gclocki = ~gclocki;

  logic [W-1:0] out_w [8];
  assign out_w[0] = N1BEG[W-1:0];
  assign out_w[1] = N1BEG[2*W-1:W];
  assign out_w[2] = S1BEG[W-1:0];
  assign out_w[3] = S1BEG[2*W-1:W];
  assign out_w[4] = E1BEG[W-1:0];
  assign out_w[5] = E1BEG[2*W-1:W];
  assign out_w[6] = W1BEG[W-1:0];
  assign out_w[7] = W1BEG[2*W-1:W];

  // Selector codes: 0..7 output words, 8 cfg_strbo, 9 cfg_datao, 10 CLRBEG, 11 rst, 12 clk
  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  event chk_ev;

  function automatic logic [31:0] get_actual(int sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      0, 1, 2, 3, 4, 5, 6, 7: v = 32'(out_w[sel]);
      8:  v = 32'(cfg_strbo);
      9:  v = cfg_datao;
      10: v = 32'(CLRBEG);
      11: v = 32'(rst);
      12: v = 32'(clk);
      default: v = 'x;
    endcase
    return v;
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = get_actual(e.sel);
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.nm, act, e.exp);
        end else begin
          $display("ok   %s: %h", e.nm, act);
        end
      end
    end
  end

  task automatic push(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.nm  = nm;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic do_check();
    -> chk_ev;
    #1;
  endtask

  task automatic load_frame(input int i, input logic [31:0] v);
    @(negedge gclocki);
    cfg_datai = v;
    cfg_strbi = FH'(1 << i);
    #1;
    cfg_strbi = '0;
  endtask

  // A operand on E1END0, B operand on W1END1
  task automatic set_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    E1END = {{W{1'b0}}, a};
    W1END = {b, {W{1'b0}}};
  endtask

  task automatic push_s1(input string nm, input logic [W-1:0] ar, input logic [W-1:0] q);
    push({nm, "_ar"}, 2, 32'(ar));
    push({nm, "_q"},  3, 32'(q));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    CLREND    = 1'b1;
    cfg_strbi = '0;
    cfg_datai = '0;
    N1END = '0; S1END = '0; E1END = '0; W1END = '0;

    load_frame(0, 32'hCCCC89CC);
    load_frame(1, 32'h0000003C);
    #1;
    for (int k = 0; k < 8; k++) push($sformatf("reset_out%0d", k), k, 32'h0);
    push("reset_clrbeg", 10, 32'h1);
    push("reset_rst", 11, 32'h1);
    do_check();

    // 10 * 50 = 500 with both operands valid
    @(negedge gclocki);
    CLREND = 1'b0;
    set_ab(13'h100A, 13'h1032);
    @(posedge gclocki); #1;
    push_s1("mul10x50", 13'h100A, 13'h11F4);
    for (int k = 0; k < 8; k++) if (k != 2 && k != 3) push($sformatf("idle_out%0d", k), k, 32'h0);
    push("run_clrbeg", 10, 32'h0);
    push("run_rst", 11, 32'h0);
    push("clk_high", 12, 32'h1);
    do_check();

    // 4095*4095 = 16769025, high half 4094
    load_frame(1, 32'h0000007C);
    set_ab(13'h1FFF, 13'h1FFF);
    @(posedge gclocki); #1;
    push_s1("max_hi", 13'h1FFF, 13'h1FFE);
    do_check();

    // -3 * 50 = -150 signed: high half all ones
    load_frame(1, 32'h0000017C);
    set_ab(13'h1FFD, 13'h1032);
    @(posedge gclocki); #1;
    push_s1("signed_hi", 13'h1FFD, 13'h1FFF);
    do_check();

    // 4093 * 50 = 204650 unsigned: high half 49
    load_frame(1, 32'h0000007C);
    set_ab(13'h1FFD, 13'h1032);
    @(posedge gclocki); #1;
    push_s1("unsigned_hi", 13'h1FFD, 13'h1031);
    do_check();

    // bypass: Q follows 7*9 with no clock, AR still holds the last sampled A
    load_frame(1, 32'h000000BC);
    set_ab(13'h1007, 13'h1009);
    #1;
    push_s1("bypass_comb", 13'h1FFD, 13'h103F);
    do_check();
    @(posedge gclocki); #1;
    push_s1("bypass_clk", 13'h1007, 13'h103F);
    do_check();

    // A invalid -> Q valid low, data still the product
    load_frame(1, 32'h0000003C);
    set_ab(13'h000A, 13'h1032);
    @(posedge gclocki); #1;
    push_s1("a_invalid", 13'h000A, 13'h01F4);
    do_check();

    // asynchronous clear between edges
    set_ab(13'h100A, 13'h1032);
    @(posedge gclocki); #1;
    push_s1("pre_clear", 13'h100A, 13'h11F4);
    do_check();
    #1;
    CLREND = 1'b1;
    #1;
    push_s1("async_clear", 13'h0, 13'h0);
    push("clear_clrbeg", 10, 32'h1);
    do_check();
    @(posedge gclocki); #1;
    push_s1("hold_clear", 13'h0, 13'h0);
    push("hold_rst", 11, 32'h1);
    do_check();
    @(negedge gclocki);
    CLREND = 1'b0;
    @(posedge gclocki); #1;
    push_s1("after_clear", 13'h100A, 13'h11F4);
    do_check();

    // config pass-through
    @(negedge gclocki);
    cfg_datai = 32'hDEADBEEF;
    #1;
    push("datao", 9, 32'hDEADBEEF);
    push("strbo_idle", 8, 32'h0);
    push("clk_low", 12, 32'h0);
    do_check();
    cfg_datai = 32'h00000000;
    cfg_strbi = 2'b01;
    #1;
    push("strbo_set", 8, 32'h1);
    push("datao_zero", 9, 32'h0);
    do_check();
    cfg_strbi = 2'b00;

    // frame0 now all zero: every output routes N1END0
    N1END = {13'h0000, 13'h1ABC};
    #1;
    for (int k = 0; k < 8; k++) push($sformatf("bcast_out%0d", k), k, 32'h1ABC);
    do_check();

    // identity routing: output k takes input word k
    load_frame(0, 32'h76543210);
    N1END = {13'h1002, 13'h1001};
    S1END = {13'h1004, 13'h1003};
    E1END = {13'h1006, 13'h1005};
    W1END = {13'h1008, 13'h1007};
    #1;
    for (int k = 0; k < 8; k++) push($sformatf("route_out%0d", k), k, 32'(13'h1001 + k));
    do_check();

    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
